// File: rtl/light_pen_capture.sv
// Light-pen hit capture: correlates pen pulses with the LED scan and fires one RAM write strobe per hit.
// Build with PEN_DRAG_EN defined for continuous drawing, where every newly qualified pixel is written while the key is held.
module light_pen_capture #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HIT_MIN         = 4,
  parameter int SYNC_DELAY      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_in,
  input  logic       pen_key,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  output logic       we,
  output logic       hit_valid,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       busy
);

  // state     | meaning
  // IDLE      | key up, nothing captured
  // SEEK      | key down, counting pen pulses per scan slot
  // WAIT_SLOT | hit latched, waiting for the scan to revisit it
  // DONE      | write issued, waiting for key release
  typedef enum logic [1:0] {IDLE, SEEK, WAIT_SLOT, DONE} state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_W = $clog2(HIT_MIN + 1);

  function automatic logic [2:0] idx8(input logic [7:0] v);
    idx8 = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx8 = 3'(i);
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  state_t            state;
  logic [SYNC_DELAY-1:0] pen_sync;
  logic [SYNC_DELAY-1:0] key_sync;
  logic [15:0]       pos_pipe [SYNC_DELAY];
  logic [15:0]       pos_prev;
  logic              key_db;
  logic [DB_W-1:0]   db_cnt;
  logic [HC_W-1:0]   hit_cnt;
  logic              armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_sync <= '0;
      key_sync <= '0;
      for (int i = 0; i < SYNC_DELAY; i++) pos_pipe[i] <= 16'd0;
      pos_prev <= 16'd0;
    end else begin
      pen_sync[0] <= pen_in;
      key_sync[0] <= pen_key;
      pos_pipe[0] <= {led_row, led_col};
      for (int i = 1; i < SYNC_DELAY; i++) begin
        pen_sync[i] <= pen_sync[i-1];
        key_sync[i] <= key_sync[i-1];
        pos_pipe[i] <= pos_pipe[i-1];
      end
      pos_prev <= pos_pipe[SYNC_DELAY-1];
    end
  end

  logic pen_s, key_s;
  assign pen_s = pen_sync[SYNC_DELAY-1];
  assign key_s = key_sync[SYNC_DELAY-1];

  // The FSM reacts in the same cycle key_db takes its new level.
  logic db_flip, key_rise, key_fall;
  assign db_flip  = (key_s != key_db) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign key_rise = db_flip && key_s;
  assign key_fall = db_flip && !key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db <= 1'b0;
      db_cnt <= '0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      key_db <= key_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  logic [7:0] row_d, col_d;
  logic       valid_d, slot_change, valid_u, match_now;
  logic [2:0] new_row, new_col;
  assign row_d       = pos_pipe[SYNC_DELAY-1][15:8];
  assign col_d       = pos_pipe[SYNC_DELAY-1][7:0];
  assign valid_d     = is_onehot(row_d) && is_onehot(col_d);
  assign slot_change = pos_pipe[SYNC_DELAY-1] != pos_prev;
  assign valid_u     = is_onehot(led_row) && is_onehot(led_col);
  assign match_now   = valid_u && (idx8(led_row) == hit_row) && (idx8(led_col) == hit_col);
  assign new_row     = idx8(row_d);
  assign new_col     = idx8(col_d);

  // A slot change restarts the run at one so a run never spans two slots.
  logic [HC_W-1:0] cnt_next;
  always_comb begin
    cnt_next = '0;
    if (pen_s && valid_d) begin
      if (slot_change)                       cnt_next = HC_W'(1);
      else if (hit_cnt == HC_W'(HIT_MIN))    cnt_next = hit_cnt;
      else                                   cnt_next = hit_cnt + HC_W'(1);
    end
  end

  logic qualify, same_as_last, accept;
  assign qualify = cnt_next == HC_W'(HIT_MIN);
`ifdef PEN_DRAG_EN
  assign same_as_last = hit_valid && (new_row == hit_row) && (new_col == hit_col);
`else
  assign same_as_last = 1'b0;
`endif
  assign accept = qualify && !same_as_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we        <= 1'b0;
      hit_valid <= 1'b0;
      hit_row   <= 3'd0;
      hit_col   <= 3'd0;
      busy      <= 1'b0;
      hit_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          hit_valid <= 1'b0;
          hit_cnt   <= '0;
          if (key_rise) begin
            state <= SEEK;
            busy  <= 1'b1;
          end
        end
        SEEK: begin
          if (key_fall) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hit_valid <= 1'b0;
            hit_cnt   <= '0;
          end else if (accept) begin
            hit_row   <= new_row;
            hit_col   <= new_col;
            hit_valid <= 1'b1;
            hit_cnt   <= '0;
            armed     <= 1'b0;
            state     <= WAIT_SLOT;
          end else begin
            hit_cnt <= cnt_next;
          end
        end
        WAIT_SLOT: begin
          if (key_fall) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hit_valid <= 1'b0;
          end else if (armed && match_now) begin
            we <= 1'b1;
`ifdef PEN_DRAG_EN
            state <= SEEK;
`else
            state <= DONE;
`endif
          end else begin
            // Only a match preceded by a non-matching cycle is a fresh visit.
            armed <= !match_now;
          end
        end
        DONE: begin
          if (key_fall) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hit_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_pen_capture.sv
// Scoreboard bench for light_pen_capture: expected write strobes are queued at stimulus time and checked by a monitor.
module tb_light_pen_capture;

  localparam int DB    = 300;
  localparam int HM    = 4;
  localparam int SD    = 2;
  localparam int SLOT  = 8;
  localparam int FRAME = 64 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pen_in = 1'b0;
  logic       pen_key = 1'b0;
  logic [7:0] led_row = 8'd0;
  logic [7:0] led_col = 8'd0;
  logic       we, hit_valid, busy;
  logic [2:0] hit_row, hit_col;

  light_pen_capture #(.DEBOUNCE_CYCLES(DB), .HIT_MIN(HM), .SYNC_DELAY(SD)) dut (
    .clk(clk), .rst_n(rst_n), .pen_in(pen_in), .pen_key(pen_key),
    .led_row(led_row), .led_col(led_col), .we(we), .hit_valid(hit_valid),
    .hit_row(hit_row), .hit_col(hit_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { int r; int c; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int scan_idx = 0, scan_ph = 0, prev_idx = 0, prev_ph = 0;
  bit blank = 1'b0;

  // Scan model: row-major, column fastest, SLOT cycles per pixel; prev_* is what the DUT just sampled.
  always @(posedge clk) begin
    prev_idx = scan_idx;
    prev_ph  = scan_ph;
    #1;
    if (scan_ph == SLOT - 1) begin
      scan_ph  = 0;
      scan_idx = (scan_idx + 1) % 64;
    end else begin
      scan_ph = scan_ph + 1;
    end
    led_row = blank ? 8'd0 : 8'(1 << (scan_idx / 8));
    led_col = blank ? 8'd0 : 8'(1 << (scan_idx % 8));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we actual=row%0d_col%0d required=none", hit_row, hit_col);
      end else begin
        e = exp_q.pop_front();
        chk("we_row", 32'(hit_row), 32'(e.r));
        chk("we_col", 32'(hit_col), 32'(e.c));
        chk("we_scan_pos", 32'(prev_idx), 32'(e.r * 8 + e.c));
        chk("we_slot_phase", 32'(prev_ph), 32'd0);
        chk("we_hit_valid", 32'(hit_valid), 32'd1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pen_at(input int r, input int c, input int off, input int n);
    int t;
    int guard;
    t = r * 8 + c;
    guard = 0;
    while (!(scan_idx == t && scan_ph == off) && guard < 2 * FRAME) begin
      cyc(1);
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      checks++;
      failures++;
      $display("FAIL pen_align actual=timeout required=slot%0d", t);
    end
    pen_in = 1'b1;
    cyc(n);
    pen_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < FRAME + SLOT + 20) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL we_timeout actual=pending%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic key_press();
    int n;
    n = 0;
    pen_key = 1'b1;
    while (!busy && n < DB + 50) begin
      cyc(1);
      n++;
    end
    chk("key_press_busy", 32'(busy), 32'd1);
  endtask

  task automatic key_release();
    int n;
    n = 0;
    pen_key = 1'b0;
    while (busy && n < DB + 50) begin
      cyc(1);
      n++;
    end
    chk("key_release_busy", 32'(busy), 32'd0);
    chk("key_release_hit_valid", 32'(hit_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    pen_in  = 1'b1;
    pen_key = 1'b1;
    cyc(5);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hit_valid", 32'(hit_valid), 32'd0);
    chk("reset_hit_row", 32'(hit_row), 32'd0);
    chk("reset_hit_col", 32'(hit_col), 32'd0);

    rst_n  = 1'b1;
    pen_in = 1'b0;
    cyc(DB);
    chk("post_reset_still_idle", 32'(busy), 32'd0);
    cyc(5);
    chk("post_reset_seek", 32'(busy), 32'd1);
    key_release();

    for (int i = 0; i < 50; i++) begin
      pen_key = (i % 2 == 0);
      cyc(100);
    end
    chk("bounce_no_accept", 32'(busy), 32'd0);
    pen_key = 1'b1;
    n = 0;
    while (!busy && n < DB + 50) begin
      cyc(1);
      n++;
    end
    chk("debounce_latency", 32'(n), 32'(DB + SD));

    exp_q.push_back('{2, 5});
    pen_at(2, 5, 1, 4);
    cyc(4);
    chk("hit_valid_set", 32'(hit_valid), 32'd1);
    chk("hit_row_2", 32'(hit_row), 32'd2);
    chk("hit_col_5", 32'(hit_col), 32'd5);
    chk("no_we_before_revisit", 32'(we), 32'd0);
    drain();

`ifndef PEN_DRAG_EN
    pen_at(3, 3, 1, 4);
    cyc(4);
    chk("done_holds_row", 32'(hit_row), 32'd2);
    chk("done_holds_col", 32'(hit_col), 32'd5);
    chk("done_busy", 32'(busy), 32'd1);
    cyc(FRAME + SLOT);
`endif
    key_release();

    key_press();
    pen_at(4, 4, 1, 3);
    pen_at(5, 6, 6, 4);
    blank = 1'b1;
    cyc(3);
    pen_in = 1'b1;
    cyc(12);
    pen_in = 1'b0;
    cyc(4);
    blank = 1'b0;
    cyc(FRAME + SLOT);
    chk("short_runs_no_hit", 32'(hit_valid), 32'd0);
    chk("short_runs_seek", 32'(busy), 32'd1);

    pen_at(6, 1, 1, 4);
    cyc(4);
    chk("wait_hit_valid", 32'(hit_valid), 32'd1);
    chk("wait_hit_row", 32'(hit_row), 32'd6);
    key_release();
    cyc(FRAME);

`ifdef PEN_DRAG_EN
    key_press();
    exp_q.push_back('{1, 1});
    pen_at(1, 1, 1, 4);
    drain();
    exp_q.push_back('{1, 2});
    pen_at(1, 2, 1, 4);
    drain();
    pen_at(1, 2, 1, 4);
    cyc(FRAME + SLOT);
    chk("drag_last_row", 32'(hit_row), 32'd1);
    chk("drag_last_col", 32'(hit_col), 32'd2);
    chk("drag_hit_valid", 32'(hit_valid), 32'd1);
    key_release();
`endif

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/light_pen_capture.md
Name: light_pen_capture

Overview:
- Upstream stage of the LED matrix driver. It converts the raw light-pen photodiode and pen button into the single-cycle `we` strobe that the driver passes to the LED RAM.
- It correlates pen light pulses with the current scan position (one-hot row/col from the scan driver) and latches the hit coordinates.
- It then waits for the scan to return to that same position, so `we` lands exactly on the hit pixel's RAM address.

Parameters:
- DEBOUNCE_CYCLES, 20000: cycles `pen_key` must be stable before a level change is accepted.
- HIT_MIN, 4: consecutive synced `pen_in`-high cycles within one scan slot that qualify a hit.
- SYNC_DELAY, 2: synchroniser depth; scan position is delayed by the same count before correlation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- pen_in  in  1  raw photodiode comparator output, asynchronous, active-high
- pen_key  in  1  raw pen button, asynchronous, active-high, bouncing
- led_row  in  8  one-hot scan row (same vector the driver scans)
- led_col  in  8  one-hot scan column
- we  out  1  write strobe to LED RAM path, one clk wide
- hit_valid  out  1  high while hit_row/hit_col hold a captured hit
- hit_row  out  3  binary index of captured row
- hit_col  out  3  binary index of captured column
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset and clocking:
  - One clock domain, `clk`.
  - `rst_n` is an asynchronous, active-low reset.
  - Reset values: we=0, hit_valid=0, hit_row=0, hit_col=0, busy=0, FSM=IDLE, all counters and synchronisers 0.
- Input conditioning:
  - `pen_in` and `pen_key` each pass through a SYNC_DELAY-flop synchroniser.
  - `key_db` is the debounced key. A synced level must differ from `key_db` for DEBOUNCE_CYCLES consecutive cycles before `key_db` takes it. Any reversion restarts the count.
- Scan alignment:
  - {led_row, led_col} is delayed SYNC_DELAY cycles (`pos_d`) for correlation with synced `pen_in`.
  - The undelayed vector is used for the write-back match.
  - A position is valid only when both vectors are one-hot. Invalid positions (e.g. all-zero blanking) never count hits and never match.
  - A slot change is any cycle where `pos_d` differs from its previous value.
- FSM:
  - IDLE:
    - hit_valid=0.
    - Rising edge of `key_db` -> SEEK.
  - SEEK:
    - `hit_cnt` increments on each cycle where synced `pen_in`=1 and `pos_d` is valid.
    - `hit_cnt` clears on `pen_in`=0 or on a slot change. A slot change clears it before the same-cycle sample counts, so a run never spans two slots.
    - When `hit_cnt` reaches HIT_MIN, latch the binary indices of `pos_d` into hit_row/hit_col, set hit_valid=1, and go to WAIT_SLOT.
    - `key_db` falls -> IDLE, no write.
  - WAIT_SLOT:
    - Compare undelayed led_row/led_col indices against hit_row/hit_col.
    - On the first cycle of a match, assert we=1 for exactly one cycle -> DONE.
    - A match already in progress on WAIT_SLOT entry (same slot still active) does not fire; the write waits for the next visit of that slot.
    - `key_db` falls -> IDLE, no write, hit_valid cleared.
  - DONE:
    - hit_valid stays 1.
    - Waits for `key_db` to fall -> IDLE.
    - Exactly one `we` per key press.
- Timing:
  - `we` is registered.
  - Latency from hit qualification to `we` is at most one full scan frame plus one slot.
- Simultaneous events:
  - If the key falls in the same cycle a hit qualifies or a write would fire, key release wins: no latch, no `we`.
  - A reset mid-operation aborts immediately; `we` never glitches high.
- Counter widths:
  - `hit_cnt` saturates at HIT_MIN.
  - The debounce counter is sized with $clog2(DEBOUNCE_CYCLES+1).

Optional Feature:
- Macro: PEN_DRAG_EN.
- Defined: DONE is skipped. After `we` the FSM returns to SEEK while `key_db` stays high, so continuous drawing writes every newly qualified pixel.
  - A hit on the same coordinates as the last write is ignored until a different pixel qualifies.
  - hit_valid tracks the most recent hit.
- Undefined: single write per press, as described above.

Test Plan:
- Reset held low with pen_in=1 and key=1 -> we=0, busy=0, hit_valid=0. After release, the FSM stays IDLE until DEBOUNCE_CYCLES of stable key.
- Key bounce: toggle pen_key every 100 cycles for 5000 cycles, then hold high -> SEEK is entered exactly DEBOUNCE_CYCLES+SYNC_DELAY cycles after the final edge.
- Pen high for 4 cycles inside scan slot row=8'h04, col=8'h20 -> hit_row=2, hit_col=5, hit_valid=1. `we` pulses once, on the first cycle the undelayed scan next shows 8'h04/8'h20.
- Pen high for 3 cycles, or 2+2 cycles straddling a slot change -> no hit, we stays 0.
- Key released in WAIT_SLOT before the slot recurs -> no `we`, hit_valid=0, FSM IDLE.
- PEN_DRAG_EN: key held while the pen qualifies at (1,1), then (1,2), then (1,2) again -> exactly two `we` pulses, at slots (1,1) and (1,2).
